// File: rtl/p2s_pkg.sv
// Shared types and constants for the P2S serial frame receiver.
package p2s_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} rx_state_t;
  localparam int P2S_CNT_W    = 7;
  localparam int P2S_MIN_HALF = 3;   // minimum s_clk high/low time in clk cycles
endpackage

// File: rtl/p2s_rx_if.sv
// Parallel-side bus of the P2S receiver: frame handshake plus status/error flags.
interface p2s_rx_if #(parameter int DATA_BITS = 16);
  import p2s_pkg::*;
  logic [DATA_BITS-1:0] par_out;
  logic                 valid;
  logic                 ack;
  logic                 busy;
  logic [P2S_CNT_W-1:0] bit_cnt;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clr;

  modport master (output par_out, valid, busy, bit_cnt, frame_err, overrun,
                  input  ack, err_clr);
  modport slave  (input  par_out, valid, busy, bit_cnt, frame_err, overrun,
                  output ack, err_clr);
endinterface

// File: rtl/p2s_sync.sv
// N-stage synchronizer; EDGE=1 adds an edge register and outputs a one-cycle rise
// pulse, EDGE=0 outputs the synchronized level (used as a matched delay).
module p2s_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE    = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic o
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;

  generate
    if (EDGE) begin : g_edge
      logic dly_q, dly_d;
      always_comb dly_d = sync_q[STAGES-1];
      always_ff @(posedge clk or posedge rst)
        if (rst) dly_q <= RST_VAL;
        else     dly_q <= dly_d;
      assign o = sync_q[STAGES-1] & ~dly_q;
    end else begin : g_lvl
      assign o = sync_q[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/p2s_rx.sv
// P2S serial-to-parallel receiver: oversamples s_clk/s_dat/s_pen/s_clrn on clk,
// assembles DATA_BITS-bit frames and hands good frames out with valid/ack.
module p2s_rx
  import p2s_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic s_clk,
  input  logic s_dat,
  input  logic s_pen,
  input  logic s_clrn,
  p2s_rx_if.master rx
);
  localparam logic [0:0]           ST_IDLE  = IDLE;
  localparam logic [0:0]           ST_SHIFT = SHIFT;
  localparam logic [P2S_CNT_W-1:0] CNT_FULL = P2S_CNT_W'(DATA_BITS);
  localparam logic [P2S_CNT_W-1:0] CNT_MAX  = P2S_CNT_W'(DATA_BITS + 1);

  logic clk_rise, pen_rise, sync_dat, sync_clrn;

  p2s_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1), .RST_VAL(1'b0)) u_sclk
    (.clk(clk), .rst(rst), .d(s_clk),  .o(clk_rise));
  p2s_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b1), .RST_VAL(1'b0)) u_spen
    (.clk(clk), .rst(rst), .d(s_pen),  .o(pen_rise));
  p2s_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0), .RST_VAL(1'b1)) u_sclrn
    (.clk(clk), .rst(rst), .d(s_clrn), .o(sync_clrn));
  p2s_sync #(.STAGES(SYNC_STAGES), .EDGE(1'b0), .RST_VAL(1'b0)) u_sdat
    (.clk(clk), .rst(rst), .d(s_dat),  .o(sync_dat));

  logic [0:0]           state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, sh_base, par_q, par_d;
  logic [P2S_CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic                 end_q, end_d, good_q, good_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 load;

  // Frame end is resolved one cycle after pen_rise: the count check sees any
  // same-cycle shift, and the shift register is held for the load, then cleared.
  always_comb begin
    sh_base = end_q ? '0 : sh_q;
    sh_d    = sh_base;
    cnt_eff = cnt_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    end_d   = 1'b0;
    good_d  = 1'b0;
    if (!sync_clrn) begin
      sh_d    = '0;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      if (clk_rise) begin
        if (MSB_FIRST != 0) sh_d = {sh_base[DATA_BITS-2:0], sync_dat};
        else                sh_d = {sync_dat, sh_base[DATA_BITS-1:1]};
        cnt_eff = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        state_d = ST_SHIFT;
      end
      cnt_d = cnt_eff;
      if (pen_rise) begin
        end_d   = 1'b1;
        good_d  = (cnt_eff == CNT_FULL);
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    load    = end_q & good_q;
    par_d   = load ? sh_q : par_q;
    valid_d = valid_q;
    if (load)                  valid_d = 1'b1;
    else if (valid_q && rx.ack) valid_d = 1'b0;
    ovr_d  = (ovr_q  & ~rx.err_clr) | (load & valid_q & ~rx.ack);
    ferr_d = (ferr_q & ~rx.err_clr) | (end_q & ~good_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
      good_q  <= 1'b0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
      good_q  <= good_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx.par_out   = par_q;
  assign rx.valid     = valid_q;
  assign rx.busy      = (state_q == ST_SHIFT);
  assign rx.bit_cnt   = cnt_q;
  assign rx.frame_err = ferr_q;
  assign rx.overrun   = ovr_q;
endmodule

// File: tb/tb_p2s_rx.sv
// Bench for p2s_rx: a 16-bit MSB-first and a 64-bit LSB-first receiver share the serial pins.
module tb_p2s_rx;
  import p2s_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic s_clk = 1'b0, s_dat = 1'b0, s_pen = 1'b0, s_clrn = 1'b1;
  int   checks = 0, failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  always #5 clk = ~clk;

  p2s_rx_if #(.DATA_BITS(16)) if16 ();
  p2s_rx_if #(.DATA_BITS(64)) if64 ();

  p2s_rx #(.DATA_BITS(16), .SYNC_STAGES(2), .MSB_FIRST(1)) dut16 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_pen(s_pen),
    .s_clrn(s_clrn), .rx(if16.master));
  p2s_rx #(.DATA_BITS(64), .SYNC_STAGES(2), .MSB_FIRST(0)) dut64 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_pen(s_pen),
    .s_clrn(s_clrn), .rx(if64.master));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] d, input int n, input int half, input bit msb);
    for (int i = 0; i < n; i++) begin
      s_clk = 1'b0;
      s_dat = msb ? d[n-1-i] : d[i];
      tick(half);
      s_clk = 1'b1;
      tick(half);
    end
  endtask

  task automatic send_pen();
    s_pen = 1'b1; tick(4);
    s_pen = 1'b0; tick(2);
  endtask

  task automatic pulse_ack16();
    if16.ack = 1'b1; tick(1); if16.ack = 1'b0;
  endtask

  task automatic pulse_clr16();
    if16.err_clr = 1'b1; tick(1); if16.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    checks++;
    if ({if16.par_out, if16.valid, if16.busy, if16.bit_cnt, if16.frame_err, if16.overrun} !== '0) begin
      failures++;
      $display("FAIL reset16 got par=%h v=%b b=%b cnt=%0d fe=%b ov=%b exp all 0",
               if16.par_out, if16.valid, if16.busy, if16.bit_cnt, if16.frame_err, if16.overrun);
    end
    checks++;
    if ({if64.par_out, if64.valid, if64.bit_cnt} !== '0) begin
      failures++;
      $display("FAIL reset64 got par=%h v=%b cnt=%0d exp all 0", if64.par_out, if64.valid, if64.bit_cnt);
    end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_basic();
    exp_q.push_back(64'hA5C3);
    send_bits(64'hA5C3, 16, 4, 1'b1);
    checks++;
    if ({if16.busy, if16.bit_cnt} !== {1'b1, 7'd16}) begin
      failures++;
      $display("FAIL basic_cnt got busy=%b cnt=%0d exp busy=1 cnt=16", if16.busy, if16.bit_cnt);
    end
    s_pen = 1'b1; tick(3);
    checks++;
    if (if16.valid !== 1'b0) begin
      failures++; $display("FAIL basic_early_valid got=%b exp=0", if16.valid);
    end
    tick(1);
    checks++;
    if (if16.valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid got=%b exp=1", if16.valid);
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (if16.par_out !== exp_v[15:0]) begin
        failures++; $display("FAIL basic_par got=%h exp=%h", if16.par_out, exp_v[15:0]);
      end
    end
    checks++;
    if ({if16.frame_err, if16.busy, if16.bit_cnt} !== '0) begin
      failures++;
      $display("FAIL basic_after got fe=%b busy=%b cnt=%0d exp 0", if16.frame_err, if16.busy, if16.bit_cnt);
    end
    tick(2); s_pen = 1'b0; tick(2);
    pulse_ack16();
    checks++;
    if (if16.valid !== 1'b0) begin
      failures++; $display("FAIL basic_ack got valid=%b exp=0", if16.valid);
    end
  endtask

  task automatic test_bad_count();
    send_bits(64'h1ABC, 15, 4, 1'b1);
    send_pen();
    checks++;
    if ({if16.frame_err, if16.valid, if16.par_out} !== {1'b1, 1'b0, 16'hA5C3}) begin
      failures++;
      $display("FAIL short_frame got fe=%b v=%b par=%h exp fe=1 v=0 par=a5c3",
               if16.frame_err, if16.valid, if16.par_out);
    end
    pulse_clr16();
    checks++;
    if (if16.frame_err !== 1'b0) begin
      failures++; $display("FAIL err_clr1 got=%b exp=0", if16.frame_err);
    end
    send_bits(64'h11234, 17, 4, 1'b1);
    checks++;
    if (if16.bit_cnt !== 7'd17) begin
      failures++; $display("FAIL cnt17 got=%0d exp=17", if16.bit_cnt);
    end
    send_bits(64'h1, 1, 4, 1'b1);
    checks++;
    if (if16.bit_cnt !== 7'd17) begin
      failures++; $display("FAIL cnt_sat got=%0d exp=17", if16.bit_cnt);
    end
    send_pen();
    checks++;
    if ({if16.frame_err, if16.valid, if16.par_out, if16.bit_cnt} !== {1'b1, 1'b0, 16'hA5C3, 7'd0}) begin
      failures++;
      $display("FAIL long_frame got fe=%b v=%b par=%h cnt=%0d exp fe=1 v=0 par=a5c3 cnt=0",
               if16.frame_err, if16.valid, if16.par_out, if16.bit_cnt);
    end
    pulse_clr16();
    checks++;
    if (if16.frame_err !== 1'b0) begin
      failures++; $display("FAIL err_clr2 got=%b exp=0", if16.frame_err);
    end
  endtask

  task automatic test_overrun();
    exp_q.push_back(64'h1111); send_bits(64'h1111, 16, 4, 1'b1); send_pen();
    exp_q.push_back(64'h2222); send_bits(64'h2222, 16, 4, 1'b1); send_pen();
    checks++;
    if ({if16.valid, if16.overrun} !== 2'b11) begin
      failures++; $display("FAIL overrun_set got v=%b ov=%b exp v=1 ov=1", if16.valid, if16.overrun);
    end
    if (exp_q.size() >= 2) begin
      void'(exp_q.pop_front());
      exp_v = exp_q.pop_front();
      checks++;
      if (if16.par_out !== exp_v[15:0]) begin
        failures++; $display("FAIL overrun_par got=%h exp=%h", if16.par_out, exp_v[15:0]);
      end
    end
    pulse_ack16(); pulse_clr16();
    checks++;
    if ({if16.valid, if16.overrun} !== 2'b00) begin
      failures++; $display("FAIL overrun_clr got v=%b ov=%b exp 0 0", if16.valid, if16.overrun);
    end
    exp_q.push_back(64'h3333); send_bits(64'h3333, 16, 4, 1'b1); send_pen();
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({if16.valid, if16.par_out} !== {1'b1, exp_v[15:0]}) begin
        failures++; $display("FAIL frame3 got v=%b par=%h exp v=1 par=%h", if16.valid, if16.par_out, exp_v[15:0]);
      end
    end
    // ack lands exactly in the load cycle of the next frame
    exp_q.push_back(64'h4444); send_bits(64'h4444, 16, 4, 1'b1);
    s_pen = 1'b1; tick(3);
    if16.ack = 1'b1; tick(1); if16.ack = 1'b0;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({if16.valid, if16.overrun, if16.par_out} !== {1'b1, 1'b0, exp_v[15:0]}) begin
        failures++;
        $display("FAIL ack_in_load got v=%b ov=%b par=%h exp v=1 ov=0 par=%h",
                 if16.valid, if16.overrun, if16.par_out, exp_v[15:0]);
      end
    end
    tick(2); s_pen = 1'b0; tick(2);
    pulse_ack16();
  endtask

  task automatic test_clear();
    send_bits(64'h5A, 8, 4, 1'b1);
    s_clrn = 1'b0; tick(4);
    checks++;
    if ({if16.busy, if16.bit_cnt} !== '0) begin
      failures++; $display("FAIL clrn got busy=%b cnt=%0d exp 0 0", if16.busy, if16.bit_cnt);
    end
    s_clrn = 1'b1; tick(4);
    exp_q.push_back(64'hBEEF); send_bits(64'hBEEF, 16, 4, 1'b1); send_pen();
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({if16.valid, if16.frame_err, if16.par_out} !== {1'b1, 1'b0, exp_v[15:0]}) begin
        failures++;
        $display("FAIL after_clrn got v=%b fe=%b par=%h exp v=1 fe=0 par=%h",
                 if16.valid, if16.frame_err, if16.par_out, exp_v[15:0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(64'h1FF, 9, 4, 1'b1);
    checks++;
    if ({if16.busy, if16.bit_cnt} !== {1'b1, 7'd9}) begin
      failures++; $display("FAIL mid_pre got busy=%b cnt=%0d exp 1 9", if16.busy, if16.bit_cnt);
    end
    rst = 1'b1; #1;
    checks++;
    if ({if16.par_out, if16.valid, if16.busy, if16.bit_cnt, if16.frame_err, if16.overrun} !== '0) begin
      failures++;
      $display("FAIL mid_reset got par=%h v=%b b=%b cnt=%0d fe=%b ov=%b exp all 0",
               if16.par_out, if16.valid, if16.busy, if16.bit_cnt, if16.frame_err, if16.overrun);
    end
    s_clk = 1'b0; tick(2);
    rst = 1'b0; tick(2);
    exp_q.push_back(64'h0F0F); send_bits(64'h0F0F, 16, 4, 1'b1); send_pen();
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({if16.valid, if16.frame_err, if16.par_out} !== {1'b1, 1'b0, exp_v[15:0]}) begin
        failures++;
        $display("FAIL post_reset got v=%b fe=%b par=%h exp v=1 fe=0 par=%h",
                 if16.valid, if16.frame_err, if16.par_out, exp_v[15:0]);
      end
    end
    pulse_ack16();
  endtask

  task automatic test_lsb64();
    if64.err_clr = 1'b1; tick(1); if64.err_clr = 1'b0;
    exp_q.push_back(64'h0123456789ABCDEF);
    send_bits(64'h0123456789ABCDEF, 64, P2S_MIN_HALF, 1'b0);
    send_pen();
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({if64.valid, if64.par_out} !== {1'b1, exp_v}) begin
        failures++; $display("FAIL lsb64 got v=%b par=%h exp v=1 par=%h", if64.valid, if64.par_out, exp_v);
      end
    end
    checks++;
    if ({if64.bit_cnt, if64.frame_err} !== '0) begin
      failures++; $display("FAIL lsb64_cnt got cnt=%0d fe=%b exp 0 0", if64.bit_cnt, if64.frame_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    if16.ack = 1'b0; if16.err_clr = 1'b0;
    if64.ack = 1'b0; if64.err_clr = 1'b0;
    test_reset();
    test_basic();
    test_bad_count();
    test_overrun();
    test_clear();
    test_reset_midframe();
    test_lsb64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
